// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

  localparam int unsigned DivWidth    = 8;
  localparam int unsigned DivCntWidth = $clog2(DivWidth);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StSign,
    StDone
  } div_state_e;

endpackage

// File: rtl/seq_div_8bit_if.sv
// Start/operand/result bundle between a requester and the divider.
interface seq_div_8bit_if #(
  parameter int unsigned Width = 8
);
  logic             start;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             busy;
  logic             done;
  logic [Width-1:0] q;
  logic [Width-1:0] r;
  logic             v;
  logic             div_zero;

  modport master (
    output start, a, b,
    input  busy, done, q, r, v, div_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, v, div_zero
  );
endinterface

// File: rtl/div_trial_sub.sv
// Combinational (Width+1)-bit trial subtractor; no_borrow_o=1 means minuend >= subtrahend.
module div_trial_sub #(
  parameter int unsigned Width = 8
) (
  input  logic [Width:0] minuend_i,
  input  logic [Width:0] subtrahend_i,
  output logic [Width:0] diff_o,
  output logic           no_borrow_o
);

  assign {no_borrow_o, diff_o} = {1'b0, minuend_i} + {1'b0, ~subtrahend_i} + (Width + 2)'(1);

endmodule

// File: rtl/seq_div_8bit.sv
// Iterative signed restoring divider: magnitudes are divided MSB first, signs fixed up afterwards.
module seq_div_8bit
  import div_pkg::*;
#(
  parameter int unsigned Width = DivWidth
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_div_8bit_if.slave bus
);

  localparam int unsigned CntW = $clog2(Width);
  typedef logic [Width:0] ext_t;
  localparam ext_t MinMag = ext_t'(1) << (Width - 1);

  div_state_e       state_q, state_d;
  ext_t             dvd_q, dvd_d, dsr_q, dsr_d, rem_q, rem_d;
  logic [Width-1:0] quo_q, quo_d, q_q, q_d, r_q, r_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic             busy_q, busy_d, done_q, done_d, v_q, v_d, dz_q, dz_d;

  ext_t             a_ext, b_ext, shifted, diff;
  logic [Width-1:0] dvd_lo;
  logic             no_borrow;

  assign a_ext   = {bus.a[Width-1], bus.a};
  assign b_ext   = {bus.b[Width-1], bus.b};
  assign dvd_lo  = dvd_q[Width-1:0];
  assign shifted = ext_t'({rem_q, dvd_lo[cnt_q]});

  div_trial_sub #(
    .Width(Width)
  ) u_trial_sub (
    .minuend_i   (shifted),
    .subtrahend_i(dsr_q),
    .diff_o      (diff),
    .no_borrow_o (no_borrow)
  );

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    q_d     = q_q;
    r_d     = r_q;
    v_d     = v_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_neg_d = bus.a[Width-1];
          b_neg_d = bus.b[Width-1];
          // Magnitudes carry one extra bit so that |-2^(Width-1)| is representable.
          dvd_d   = bus.a[Width-1] ? (~a_ext + ext_t'(1)) : a_ext;
          dsr_d   = bus.b[Width-1] ? (~b_ext + ext_t'(1)) : b_ext;
          rem_d   = '0;
          cnt_d   = CntW'(Width - 1);
          v_d     = 1'b0;
          dz_d    = 1'b0;
          if (bus.b == '0) begin
            q_d     = '1;
            r_d     = bus.a;
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            busy_d  = 1'b1;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = no_borrow ? diff : shifted;
        quo_d = {quo_q[Width-2:0], no_borrow};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = StSign;
        end
      end
      StSign: begin
        q_d     = (a_neg_q ^ b_neg_q) ? (~quo_q + Width'(1)) : quo_q;
        r_d     = Width'(a_neg_q ? (~rem_q + ext_t'(1)) : rem_q);
        // Only -2^(Width-1) / -1 overflows; the wrapped quotient is already correct.
        v_d     = a_neg_q && b_neg_q && (dvd_q == MinMag) && (dsr_q == ext_t'(1));
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      v_q     <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      v_q     <= v_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.q        = q_q;
  assign bus.r        = r_q;
  assign bus.v        = v_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_seq_div_8bit.sv
// Self-checking bench for seq_div_8bit: directed vector table, handshake/reset sequences, random ops.
module tb_seq_div_8bit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_div_8bit_if #(.Width(8)) bus ();

  seq_div_8bit #(
    .Width(8)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       v;
    logic       dz;
    int         lat;
    int         inj;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: signed truncating division with the divide-by-zero and overflow rules.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic v, output logic dz, output int lat);
    int sa;
    int sb;
    sa  = $signed(a);
    sb  = $signed(b);
    v   = 1'b0;
    dz  = 1'b0;
    lat = 10;
    if (sb == 0) begin
      q   = 8'hFF;
      r   = a;
      dz  = 1'b1;
      lat = 1;
    end else if (sa == -128 && sb == -1) begin
      q = 8'h80;
      r = 8'h00;
      v = 1'b1;
    end else begin
      q = 8'(sa / sb);
      r = 8'(sa % sb);
    end
  endfunction

  // Pulses start with (a,b); optionally re-pulses start with other operands at cycle inj.
  // lat counts negedges after the accepting edge until done is seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int inj,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic v, output logic dz, output int lat, output logic busy_ok);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    lat       = 1;
    busy_ok   = 1'b1;
    while (!bus.done && lat < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (lat == inj) begin
        bus.start = 1'b1;
        bus.a     = 8'd50;
        bus.b     = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    if (bus.busy) busy_ok = 1'b0;
    q  = bus.q;
    r  = bus.r;
    v  = bus.v;
    dz = bus.div_zero;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] gq, gr, eq, er, ra, rb;
    logic       gv, gdz, ev, edz, bok, seen;
    int         glat, elat;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("reset_q", bus.q, 0);
    check("reset_r", bus.r, 0);
    check("reset_v", bus.v, 0);
    check("reset_dz", bus.div_zero, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);

    //        a      b      q      r      v     dz    lat inj
    vecs[0] = '{8'h07, 8'h02, 8'h03, 8'h01, 1'b0, 1'b0, 10, 0};
    vecs[1] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 10, 0};
    vecs[2] = '{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, 10, 0};
    vecs[3] = '{8'h80, 8'h7F, 8'hFF, 8'hFF, 1'b0, 1'b0, 10, 0};
    vecs[4] = '{8'h7F, 8'hFF, 8'h81, 8'h00, 1'b0, 1'b0, 10, 0};
    vecs[5] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b1, 1'b0, 10, 0};
    vecs[6] = '{8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 10, 0};
    vecs[7] = '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b0, 1'b1, 1, 0};
    vecs[8] = '{8'h06, 8'h03, 8'h02, 8'h00, 1'b0, 1'b0, 10, 0};
    vecs[9] = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 10, 3};

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].inj, gq, gr, gv, gdz, glat, bok);
      check($sformatf("vec%0d_q", i), gq, vecs[i].q);
      check($sformatf("vec%0d_r", i), gr, vecs[i].r);
      check($sformatf("vec%0d_v", i), gv, vecs[i].v);
      check($sformatf("vec%0d_dz", i), gdz, vecs[i].dz);
      check($sformatf("vec%0d_lat", i), glat, vecs[i].lat);
      check($sformatf("vec%0d_busy", i), bok, 1);
    end

    // start raised during the DONE cycle must be ignored.
    run_op(8'd7, 8'd2, 0, gq, gr, gv, gdz, glat, bok);
    bus.start = 1'b1;
    bus.a     = 8'd9;
    bus.b     = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_start_busy", bus.busy, 0);
    @(negedge clk);
    check("done_start_busy2", bus.busy, 0);
    check("done_start_done", bus.done, 0);
    check("done_start_q", bus.q, 8'h03);

    // Reset five cycles into an operation aborts it with no done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd100;
    bus.b     = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_q", bus.q, 0);
    check("abort_r", bus.r, 0);
    check("abort_busy", bus.busy, 0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);

    run_op(8'd100, 8'd7, 0, gq, gr, gv, gdz, glat, bok);
    check("post_reset_q", gq, 8'h0E);
    check("post_reset_r", gr, 8'h02);
    check("post_reset_lat", glat, 10);

    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 8'h00;
      if ($urandom_range(0, 7) == 0) ra = 8'h80;
      if ($urandom_range(0, 7) == 0) rb = 8'hFF;
      model(ra, rb, eq, er, ev, edz, elat);
      run_op(ra, rb, 0, gq, gr, gv, gdz, glat, bok);
      check($sformatf("rnd%0d_q(%0h/%0h)", i, ra, rb), gq, eq);
      check($sformatf("rnd%0d_r(%0h/%0h)", i, ra, rb), gr, er);
      check($sformatf("rnd%0d_v", i), gv, ev);
      check($sformatf("rnd%0d_dz", i), gdz, edz);
      check($sformatf("rnd%0d_lat", i), glat, elat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
